// File: rtl/culsans_pkg.sv
// culsans_pkg -- shared types for the exit monitor.
//   exit_word_t : one hart's 32-bit exit word, {code[30:0], exited}
//   state_e     : monitor FSM states (RUN / DONE / TIMEOUT)
package culsans_pkg;

  typedef struct packed {
    logic [30:0] code;
    logic        exited;
  } exit_word_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DONE    = 2'd1,
    TIMEOUT = 2'd2
  } state_e;

endpackage

// File: rtl/culsans_exit_capture.sv
// culsans_exit_capture -- per-hart sticky exit flag and return-code register.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clear_i       synchronous re-arm; wins over a same-cycle capture
//   arm_i         capture allowed this cycle (monitor running, hart monitored)
//   exit_i        hart's exit word
//   capture_o     this edge latches the hart's exit (combinational)
//   exited_o      sticky exited flag
//   code_o        return code latched with the flag
module culsans_exit_capture
  import culsans_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        arm_i,
  input  exit_word_t  exit_i,
  output logic        capture_o,
  output logic        exited_o,
  output logic [30:0] code_o
);

  // Only the first exit is taken; later changes to the word are ignored
  // until the next clear.
  assign capture_o = arm_i && exit_i.exited && !exited_o && !clear_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exited_o <= 1'b0;
      code_o   <= '0;
    end else if (clear_i) begin
      exited_o <= 1'b0;
      code_o   <= '0;
    end else if (capture_o) begin
      exited_o <= 1'b1;
      code_o   <= exit_i.code;
    end
  end

endmodule

// File: rtl/culsans_exit_monitor.sv
// culsans_exit_monitor -- watches NumHarts exit words and reports when the
// run has finished, whether it passed, and the first failing hart/code.
// Optional watchdog: define CULSANS_EXIT_WDT_EN to enable a TimeoutCycles
// cycle limit on the RUN state; otherwise TIMEOUT is unreachable.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   exit_i        per-hart exit word, bit0 = exited, [31:1] = return code
//   hart_mask_i   1 = hart monitored, 0 = treated as exited with code 0
//   clear_i       synchronous re-arm pulse
//   exited_o      sticky per-hart exit flags
//   done_o        run finished (all exited, or timeout)
//   pass_o        finished with every captured code zero and no timeout
//   fail_hart_o   index of first failing hart
//   code_o        return code of first failing hart, 0 if none
//   timeout_o     watchdog expired
module culsans_exit_monitor
  import culsans_pkg::*;
#(
  parameter  int NumHarts      = 2,
  parameter  int TimeoutCycles = 1_000_000,
  localparam int HartIdxW      = (NumHarts > 1) ? $clog2(NumHarts) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumHarts-1:0][31:0] exit_i,
  input  logic [NumHarts-1:0]      hart_mask_i,
  input  logic                     clear_i,
  output logic [NumHarts-1:0]      exited_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [HartIdxW-1:0]      fail_hart_o,
  output logic [30:0]              code_o,
  output logic                     timeout_o
);

  if (NumHarts < 1 || NumHarts > 16 || TimeoutCycles < 2) begin : g_bad_params
    $error("culsans_exit_monitor: parameter out of range");
  end

  state_e                     state_reg;
  logic                       run;
  logic [NumHarts-1:0]        exited;
  logic [NumHarts-1:0]        capture;
  logic [NumHarts-1:0][30:0]  hart_code;
  logic                       all_done;
  logic                       new_fail;
  logic [HartIdxW-1:0]        new_idx;
  logic                       fail_seen_reg;
  logic [HartIdxW-1:0]        fail_idx_reg;
  logic                       done_reg, pass_reg, timeout_reg;
  logic                       wdt_fire;

  assign run = (state_reg == RUN);

  for (genvar gi = 0; gi < NumHarts; gi++) begin : g_cap
    culsans_exit_capture u_cap (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (clear_i),
      .arm_i     (run && hart_mask_i[gi]),
      .exit_i    (exit_word_t'(exit_i[gi])),
      .capture_o (capture[gi]),
      .exited_o  (exited[gi]),
      .code_o    (hart_code[gi])
    );
  end

  // Unmonitored harts count as already exited.
  assign all_done = &(exited | ~hart_mask_i);

  // Lowest-index non-zero capture this cycle (descending scan, last hit wins).
  always_comb begin
    new_fail = 1'b0;
    new_idx  = '0;
    for (int h = NumHarts - 1; h >= 0; h--) begin
      if (capture[h] && (exit_i[h][31:1] != 31'd0)) begin
        new_fail = 1'b1;
        new_idx  = HartIdxW'(h);
      end
    end
  end

`ifdef CULSANS_EXIT_WDT_EN
  localparam int            CntW    = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_reg;
  logic            all_done_next;

  // A final exit landing on the expiry edge suppresses the timeout; the
  // FSM then moves to DONE on the following edge.
  assign all_done_next = &(exited | capture | ~hart_mask_i);
  assign wdt_fire      = run && (cnt_reg == CntLast) && !all_done_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (clear_i) begin
      cnt_reg <= '0;
    end else if (run && (cnt_reg != CntLast)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
`else
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= RUN;
      done_reg      <= 1'b0;
      pass_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      fail_seen_reg <= 1'b0;
      fail_idx_reg  <= '0;
    end else if (clear_i) begin
      state_reg     <= RUN;
      done_reg      <= 1'b0;
      pass_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      fail_seen_reg <= 1'b0;
      fail_idx_reg  <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!fail_seen_reg && new_fail) begin
            fail_seen_reg <= 1'b1;
            fail_idx_reg  <= new_idx;
          end
          // With all harts already exited no capture can happen this edge,
          // so fail_seen_reg is final here.
          if (all_done) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            pass_reg  <= !fail_seen_reg;
          end else if (wdt_fire) begin
            state_reg   <= TIMEOUT;
            done_reg    <= 1'b1;
            timeout_reg <= 1'b1;
          end
        end
        DONE, TIMEOUT: ;
        default: state_reg <= RUN;
      endcase
    end
  end

  assign exited_o    = exited;
  assign done_o      = done_reg;
  assign pass_o      = pass_reg;
  assign timeout_o   = timeout_reg;
  assign fail_hart_o = fail_idx_reg;
  // The per-hart code registers are sticky, so the first failure's code is
  // read back through the latched index.
  assign code_o      = fail_seen_reg ? hart_code[fail_idx_reg] : 31'd0;

endmodule

// File: tb/tb_culsans_exit_monitor.sv
// Testbench for culsans_exit_monitor (NumHarts=2, TimeoutCycles=100).
// Watchdog scenarios follow CULSANS_EXIT_WDT_EN.
module tb_culsans_exit_monitor;

  localparam int NH = 2;
  localparam int TO = 100;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NH-1:0][31:0]  exit_w;
  logic [NH-1:0]        mask;
  logic                 clear;
  logic [NH-1:0]        exited;
  logic                 done, pass, timeout;
  logic [0:0]           fail_hart;
  logic [30:0]          code;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  culsans_exit_monitor #(
    .NumHarts      (NH),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .exit_i      (exit_w),
    .hart_mask_i (mask),
    .clear_i     (clear),
    .exited_o    (exited),
    .done_o      (done),
    .pass_o      (pass),
    .fail_hart_o (fail_hart),
    .code_o      (code),
    .timeout_o   (timeout)
  );

  // Reference model: run phase (0 run, 1 done, 2 timeout), per-hart
  // captured flags/codes, first failure, cycles spent running.
  bit          m_exited [NH];
  int          m_phase;
  bit          m_fail_seen;
  int          m_fail_idx;
  logic [30:0] m_fail_code;
  int          m_cnt;

  task automatic model_reset();
    for (int h = 0; h < NH; h++) m_exited[h] = 1'b0;
    m_phase     = 0;
    m_fail_seen = 1'b0;
    m_fail_idx  = 0;
    m_fail_code = '0;
    m_cnt       = 0;
  endtask

  task automatic model_edge();
    bit all_before;
    bit all_after;
    if (clear) begin
      model_reset();
      return;
    end
    if (m_phase != 0) return;
    all_before = 1'b1;
    for (int h = 0; h < NH; h++) if (mask[h] && !m_exited[h]) all_before = 1'b0;
    if (all_before) begin
      m_phase = 1;
      return;
    end
    for (int h = 0; h < NH; h++) begin
      if (mask[h] && exit_w[h][0] && !m_exited[h]) begin
        m_exited[h] = 1'b1;
        if (!m_fail_seen && exit_w[h][31:1] != 31'd0) begin
          m_fail_seen = 1'b1;
          m_fail_idx  = h;
          m_fail_code = exit_w[h][31:1];
        end
      end
    end
`ifdef CULSANS_EXIT_WDT_EN
    all_after = 1'b1;
    for (int h = 0; h < NH; h++) if (mask[h] && !m_exited[h]) all_after = 1'b0;
    if (m_cnt >= TO - 1 && !all_after) m_phase = 2;
    else m_cnt++;
`else
    all_after = 1'b0;
`endif
  endtask

  // One clock edge; outputs are then sampled on the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    clear  = 1'b0;
    mask   = '0;
    exit_w = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (exited !== 2'b00) begin tests_failed++; $display("FAIL reset_exited: got %b expected 00", exited); end
    tests_run++;
    if (done !== 1'b0 || pass !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got done=%b pass=%b to=%b expected 0 0 0", done, pass, timeout);
    end
    tests_run++;
    if (code !== 31'd0 || fail_hart !== 1'b0) begin
      tests_failed++; $display("FAIL reset_code: got code=%0h hart=%0d expected 0 0", code, fail_hart);
    end
    $display("[TB] reset checked");
  endtask

  // hart0 exits at cycle 10, hart1 at cycle 20, done registered at cycle 21.
  task automatic test_pass_sequence();
    do_reset();
    mask = 2'b11;
    for (int c = 1; c <= 21; c++) begin
      exit_w[0] = (c >= 10) ? 32'h1 : 32'h0;
      exit_w[1] = (c >= 20) ? 32'h1 : 32'h0;
      tick();
      if (c == 10) begin
        tests_run++;
        if (exited !== 2'b01 || done !== 1'b0) begin
          tests_failed++; $display("FAIL pass_seq_c10: got ex=%b done=%b expected 01 0", exited, done);
        end
      end
      if (c == 20) begin
        tests_run++;
        if (exited !== 2'b11 || done !== 1'b0) begin
          tests_failed++; $display("FAIL pass_seq_c20: got ex=%b done=%b expected 11 0", exited, done);
        end
      end
      if (c == 21) begin
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b1 || code !== 31'd0 || timeout !== 1'b0) begin
          tests_failed++;
          $display("FAIL pass_seq_c21: got done=%b pass=%b code=%0h to=%b expected 1 1 0 0", done, pass, code, timeout);
        end
      end
    end
    $display("[TB] pass sequence: done=%b pass=%b code=%0h", done, pass, code);
  endtask

  task automatic test_same_cycle_fail();
    do_reset();
    mask      = 2'b11;
    exit_w[0] = 32'h7;
    exit_w[1] = 32'h15;
    tick();
    tests_run++;
    if (exited !== 2'b11 || fail_hart !== 1'b0 || code !== 31'd3 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_capture: got ex=%b hart=%0d code=%0h done=%b expected 11 0 3 0", exited, fail_hart, code, done);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b0 || code !== 31'd3 || fail_hart !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_done: got done=%b pass=%b code=%0h hart=%0d expected 1 0 3 0", done, pass, code, fail_hart);
    end
    exit_w[0] = 32'h9;
    tick();
    tests_run++;
    if (code !== 31'd3 || done !== 1'b1) begin
      tests_failed++; $display("FAIL done_ignores_exit: got code=%0h done=%b expected 3 1", code, done);
    end
    $display("[TB] same-cycle failure: hart=%0d code=%0h", fail_hart, code);
  endtask

  // Continues from the DONE state left by test_same_cycle_fail.
  task automatic test_clear();
    clear     = 1'b1;
    exit_w[0] = 32'hB;
    tick();
    clear = 1'b0;
    tests_run++;
    if (exited !== 2'b00 || done !== 1'b0 || pass !== 1'b0 || code !== 31'd0 || fail_hart !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_state: got ex=%b done=%b pass=%b code=%0h hart=%0d expected 00 0 0 0 0",
               exited, done, pass, code, fail_hart);
    end
    mask      = 2'b01;
    exit_w[0] = 32'h5;
    exit_w[1] = 32'h0;
    tick();
    tests_run++;
    if (exited !== 2'b01 || code !== 31'd2 || fail_hart !== 1'b0) begin
      tests_failed++; $display("FAIL clear_recapture: got ex=%b code=%0h hart=%0d expected 01 2 0", exited, code, fail_hart);
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      tests_failed++; $display("FAIL clear_redone: got done=%b pass=%b expected 1 0", done, pass);
    end
    $display("[TB] clear and re-arm: code=%0h done=%b", code, done);
  endtask

  task automatic test_mask();
    do_reset();
    mask      = 2'b01;
    exit_w[0] = 32'h1;
    tick();
    tick();
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b1 || exited !== 2'b01) begin
      tests_failed++; $display("FAIL mask_01: got done=%b pass=%b ex=%b expected 1 1 01", done, pass, exited);
    end
    mask  = 2'b00;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL mask_00_clear: got done=%b expected 0", done); end
    tick();
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b1 || exited !== 2'b00) begin
      tests_failed++; $display("FAIL mask_00_done: got done=%b pass=%b ex=%b expected 1 1 00", done, pass, exited);
    end
    $display("[TB] mask scenarios: done=%b pass=%b", done, pass);
  endtask

  task automatic test_watchdog();
`ifdef CULSANS_EXIT_WDT_EN
    do_reset();
    mask = 2'b11;
    for (int e = 1; e <= TO; e++) begin
      exit_w[0] = (e >= 5) ? 32'h7 : 32'h0;
      tick();
      if (e == TO - 1) begin
        tests_run++;
        if (done !== 1'b0 || timeout !== 1'b0) begin
          tests_failed++; $display("FAIL wdt_early: got done=%b to=%b expected 0 0", done, timeout);
        end
      end
    end
    tests_run++;
    if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0 || code !== 31'd3 || exited !== 2'b01) begin
      tests_failed++;
      $display("FAIL wdt_expire: got done=%b to=%b pass=%b code=%0h ex=%b expected 1 1 0 3 01",
               done, timeout, pass, code, exited);
    end
    exit_w[1] = 32'h1;
    tick();
    tests_run++;
    if (exited !== 2'b01 || timeout !== 1'b1) begin
      tests_failed++; $display("FAIL wdt_hold: got ex=%b to=%b expected 01 1", exited, timeout);
    end
    // Final exit captured on the expiry edge: exit wins.
    do_reset();
    mask = 2'b11;
    for (int e = 1; e <= TO + 1; e++) begin
      exit_w[0] = 32'h1;
      exit_w[1] = (e >= TO) ? 32'h1 : 32'h0;
      tick();
      if (e == TO) begin
        tests_run++;
        if (timeout !== 1'b0 || done !== 1'b0 || exited !== 2'b11) begin
          tests_failed++; $display("FAIL wdt_coincide: got to=%b done=%b ex=%b expected 0 0 11", timeout, done, exited);
        end
      end
    end
    tests_run++;
    if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0) begin
      tests_failed++; $display("FAIL wdt_exit_wins: got done=%b pass=%b to=%b expected 1 1 0", done, pass, timeout);
    end
    $display("[TB] watchdog enabled: timeout and exit-wins checked");
`else
    int bad;
    bad = 0;
    do_reset();
    mask = 2'b11;
    for (int e = 0; e < 1000; e++) begin
      tick();
      if (done !== 1'b0 || timeout !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL no_wdt_idle: got %0d cycles with done/timeout set expected 0", bad);
    end
    $display("[TB] watchdog disabled: 1000 idle cycles");
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    mask      = 2'b11;
    exit_w[0] = 32'h7;
    tick();
    tests_run++;
    if (exited !== 2'b01 || code !== 31'd3) begin
      tests_failed++; $display("FAIL async_pre: got ex=%b code=%0h expected 01 3", exited, code);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (exited !== 2'b00 || done !== 1'b0 || pass !== 1'b0 || code !== 31'd0 || fail_hart !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got ex=%b done=%b pass=%b code=%0h hart=%0d to=%b expected all 0",
               exited, done, pass, code, fail_hart, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exit_w[0] = 32'h0;
    exit_w[1] = 32'h1;
    tick();
    tick();
    tests_run++;
    if (exited !== 2'b10 || done !== 1'b0 || code !== 31'd0) begin
      tests_failed++; $display("FAIL async_discard: got ex=%b done=%b code=%0h expected 10 0 0", exited, done, code);
    end
    $display("[TB] async reset mid-run checked");
  endtask

  task automatic test_random();
    logic [NH-1:0] ee;
    logic          e_done, e_pass, e_to;
    logic [30:0]   e_code;
    logic [0:0]    e_hart;
    int            errs;
    errs = 0;
    do_reset();
    mask = 2'($urandom_range(0, 3));
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int h = 0; h < NH; h++) begin
        exit_w[h][0]    = ($urandom_range(0, 7) == 0);
        exit_w[h][31:1] = ($urandom_range(0, 3) < 2) ? 31'd0 : 31'($urandom_range(1, 6));
      end
      if ($urandom_range(0, 39) == 0) mask = 2'($urandom_range(0, 3));
      clear = ($urandom_range(0, 24) == 0);
      tick();
      for (int h = 0; h < NH; h++) ee[h] = m_exited[h];
      e_done = (m_phase != 0);
      e_pass = (m_phase == 1) && !m_fail_seen;
      e_to   = (m_phase == 2);
      e_code = m_fail_seen ? m_fail_code : 31'd0;
      e_hart = m_fail_seen ? 1'(m_fail_idx) : 1'b0;
      tests_run++;
      if (exited !== ee || done !== e_done || pass !== e_pass || timeout !== e_to ||
          code !== e_code || fail_hart !== e_hart) begin
        tests_failed++;
        errs++;
        $display("FAIL rand_cyc%0d: got ex=%b done=%b pass=%b to=%b hart=%0d code=%0h expected ex=%b done=%b pass=%b to=%b hart=%0d code=%0h",
                 cyc, exited, done, pass, timeout, fail_hart, code, ee, e_done, e_pass, e_to, e_hart, e_code);
      end
    end
    clear = 1'b0;
    $display("[TB] random: 600 cycles, %0d mismatching", errs);
  endtask

  initial begin
    rst    = 1'b1;
    clear  = 1'b0;
    mask   = '0;
    exit_w = '0;
    model_reset();
    test_reset();
    test_pass_sequence();
    test_same_cycle_fail();
    test_clear();
    test_mask();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/culsans_exit_monitor.md
CULSANS_EXIT_MONITOR -- requirements
Module: culsans_exit_monitor

Interface
REQ-001 SHALL have parameter NumHarts, default 2, meaning number of monitored exit channels (1..16).
REQ-002 SHALL have parameter TimeoutCycles, default 1_000_000, meaning watchdog limit in clk_i cycles (>=2).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port exit_i  input  NumHarts x 32  per-hart exit word; bit0 = exited, [31:1] = return code.
REQ-006 SHALL have port hart_mask_i  input  NumHarts  1 = hart monitored; 0 = hart treated as already exited with code 0.
REQ-007 SHALL have port clear_i  input  1  synchronous re-arm pulse.
REQ-008 SHALL have port exited_o  output  NumHarts  sticky per-hart exit flags.
REQ-009 SHALL have port done_o  output  1  run finished (all exited, or timeout).
REQ-010 SHALL have port pass_o  output  1  done with all captured codes zero and no timeout.
REQ-011 SHALL have port fail_hart_o  output  max(1,$clog2(NumHarts))  index of first failing hart.
REQ-012 SHALL have port code_o  output  31  return code of first failing hart; 0 if none.
REQ-013 SHALL have port timeout_o  output  1  watchdog expired.

Function
REQ-014 SHALL implement FSM states RUN, DONE, TIMEOUT; RUN after reset.
REQ-015 SHALL, in RUN, set exited_o[h] on the first rising edge where hart_mask_i[h]=1 and exit_i[h][0]=1, latching exit_i[h][31:1]; later changes to exit_i[h] ignored until clear.
REQ-016 SHALL capture the first non-zero code into code_o/fail_hart_o; later failures ignored; same-cycle failures resolved to lowest index.
REQ-017 SHALL transition RUN->DONE on the edge after (exited_o | ~hart_mask_i) becomes all-ones; done_o is registered, one cycle after the last capture.
REQ-018 SHALL drive pass_o = 1 only in DONE with no failure captured.
REQ-019 SHALL hold DONE and TIMEOUT until clear_i or reset; exit_i ignored there.
REQ-020 SHALL, on clear_i=1, next cycle enter RUN, clear exited_o, code_o, fail_hart_o, watchdog counter; clear_i wins over same-cycle capture.
REQ-021 SHALL, with hart_mask_i all-zero in RUN, enter DONE with pass_o=1 on the next edge.

Reset
REQ-022 SHALL, while rst_i=1, force state RUN, exited_o=0, done_o=0, pass_o=0, fail_hart_o=0, code_o=0, timeout_o=0, counter=0, independent of clk_i.
REQ-023 SHALL discard any partial capture if reset asserts mid-run.

Configuration
REQ-024 SHALL, with CULSANS_EXIT_WDT_EN defined, count cycles in RUN and enter TIMEOUT when count reaches TimeoutCycles-1: done_o=1, timeout_o=1, pass_o=0, captured codes retained.
REQ-025 SHALL, if the final exit and expiry coincide, go to DONE (exit wins).
REQ-026 SHALL, without CULSANS_EXIT_WDT_EN, instantiate no counter, tie timeout_o to 0, leave TIMEOUT unreachable.

Structure
REQ-027 SHALL place exit_word_t (packed: code[30:0], exited) and the FSM state enum in culsans_pkg.
REQ-028 SHALL use one sub-module culsans_exit_capture per hart (sticky flag + code register), generated NumHarts times.

Verification
REQ-029 SHALL test: NumHarts=2, mask 2'b11, hart0 exit 0x1 at cycle 10, hart1 exit 0x1 at cycle 20 -> done_o=1, pass_o=1 at cycle 21, code_o=0.
REQ-030 SHALL test: hart1 writes 0x15 (code 0xA), hart0 writes 0x7 (code 3) same cycle -> fail_hart_o=0, code_o=3, pass_o=0 after both exit.
REQ-031 SHALL test: WDT_EN, TimeoutCycles=100, no exits -> timeout_o=1, done_o=1 on cycle 100; without macro, done_o stays 0 for 1000 cycles.
REQ-032 SHALL test: mask 2'b01, hart0 exits 0x1, hart1 never -> done_o=1, pass_o=1.
REQ-033 SHALL test: clear_i pulse in DONE, then hart0 exit 0x5 -> prior state cleared, new code_o=2.
REQ-034 SHALL test: rst_i asserted between clock edges mid-run -> all outputs 0 immediately, before next clk_i edge.
